// File: rtl/ps2_kbmatrix_if.sv
// PS/2 line inputs and key-matrix/scancode outputs of the keyboard front end.
// The master side drives the PS/2 lines; the slave side is the ps2_kbmatrix block.
interface ps2_kbmatrix_if;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [63:0] kbmatrix;
    logic        scan_stb;
    logic [7:0]  scan_code;
    logic        frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  kbmatrix, scan_stb, scan_code, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output kbmatrix, scan_stb, scan_code, frame_err
    );
endinterface

// File: rtl/ps2_kbmatrix.sv
// PS/2 Set-2 keyboard front end: line filter, frame receiver and make/break decoder
// driving the active-low Z88 key matrix. Define PS2_EXT_EN to enable E0-prefixed cursor keys.
module ps2_kbmatrix #(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_kbmatrix_if.slave bus
);
    localparam int unsigned FCW       = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [14:0]    TMO_LAST  = 15'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           filt_clk;
    logic [FCW-1:0] filt_cnt;
    logic           fe;

    rx_state_t      state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [14:0]    tmo_cnt;
    logic           scan_stb;
    logic [7:0]     scan_code;
    logic           frame_err;
    logic           par_ok;

    logic [63:0]    kb;
    logic           brk;
    logic           ext;
    logic           map_hit;
    logic [5:0]     map_idx;

    assign bus.kbmatrix  = kb;
    assign bus.scan_stb  = scan_stb;
    assign bus.scan_code = scan_code;
    assign bus.frame_err = frame_err;

    // Two-flop synchronizers; idle lines are high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Agreement filter: flips only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
                fe       <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    assign par_ok = ^{shreg, par_bit};

    // Frame receiver; an fe always wins over a coincident timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par_bit   <= 1'b0;
            tmo_cnt   <= 15'd0;
            scan_stb  <= 1'b0;
            scan_code <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            scan_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (fe) begin
                tmo_cnt <= 15'd0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (dat_s2 && par_ok) begin
                            scan_code <= shreg;
                            scan_stb  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state     <= S_IDLE;
                    tmo_cnt   <= 15'd0;
                    frame_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 15'd1;
                end
            end
        end
    end

    // Set-2 scancode to matrix bit (row*8 + col)
    always_comb begin
        map_hit = 1'b1;
        map_idx = 6'd0;
        case ({ext, scan_code})
            9'h05A: map_idx = 6'd6;   // ENTER
            9'h012: map_idx = 6'd62;  // LSHIFT
            9'h059: map_idx = 6'd63;  // RSHIFT
            9'h029: map_idx = 6'd46;  // SPACE
            9'h076: map_idx = 6'd61;  // ESC
            9'h00D: map_idx = 6'd53;  // TAB
            9'h066: map_idx = 6'd7;   // DEL
            9'h016: map_idx = 6'd45;  // 1
            9'h01E: map_idx = 6'd37;  // 2
            9'h026: map_idx = 6'd29;  // 3
            9'h025: map_idx = 6'd21;  // 4
            9'h02E: map_idx = 6'd13;  // 5
            9'h036: map_idx = 6'd5;   // 6
            9'h03D: map_idx = 6'd1;   // 7
            9'h03E: map_idx = 6'd0;   // 8
            9'h046: map_idx = 6'd24;  // 9
            9'h045: map_idx = 6'd40;  // 0
            9'h015: map_idx = 6'd44;  // Q
            9'h01D: map_idx = 6'd36;  // W
            9'h024: map_idx = 6'd28;  // E
            9'h02D: map_idx = 6'd20;  // R
            9'h02C: map_idx = 6'd12;  // T
            9'h035: map_idx = 6'd4;   // Y
            9'h03C: map_idx = 6'd9;   // U
            9'h043: map_idx = 6'd8;   // I
            9'h044: map_idx = 6'd16;  // O
            9'h04D: map_idx = 6'd32;  // P
            9'h01C: map_idx = 6'd49;  // A
            9'h01B: map_idx = 6'd43;  // S
            9'h023: map_idx = 6'd27;  // D
            9'h02B: map_idx = 6'd19;  // F
            9'h034: map_idx = 6'd11;  // G
            9'h033: map_idx = 6'd2;   // H
            9'h03B: map_idx = 6'd17;  // J
            9'h042: map_idx = 6'd25;  // K
            9'h04B: map_idx = 6'd41;  // L
            9'h01A: map_idx = 6'd42;  // Z
            9'h022: map_idx = 6'd34;  // X
            9'h021: map_idx = 6'd26;  // C
            9'h02A: map_idx = 6'd18;  // V
            9'h032: map_idx = 6'd10;  // B
            9'h031: map_idx = 6'd33;  // N
            9'h03A: map_idx = 6'd50;  // M
`ifdef PS2_EXT_EN
            9'h175: map_idx = 6'd3;   // UP
            9'h172: map_idx = 6'd14;  // DOWN
            9'h16B: map_idx = 6'd30;  // LEFT
            9'h174: map_idx = 6'd22;  // RIGHT
`endif
            default: map_hit = 1'b0;
        endcase
    end

`ifndef PS2_EXT_EN
    assign ext = 1'b0;
`endif

    // Make/break decoder; matrix is active low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb  <= '1;
            brk <= 1'b0;
`ifdef PS2_EXT_EN
            ext <= 1'b0;
`endif
        end else if (scan_stb) begin
            case (scan_code)
                8'hF0: brk <= 1'b1;
                8'hE0: begin
`ifdef PS2_EXT_EN
                    ext <= 1'b1;
`endif
                end
                8'hAA, 8'h00, 8'hFF: begin
                    kb  <= '1;
                    brk <= 1'b0;
`ifdef PS2_EXT_EN
                    ext <= 1'b0;
`endif
                end
                default: begin
                    if (map_hit) kb[map_idx] <= brk;
                    brk <= 1'b0;
`ifdef PS2_EXT_EN
                    ext <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbmatrix.sv
// Scoreboard bench for ps2_kbmatrix: drives PS/2 frames, compares strobes/errors and the key matrix.
module tb_ps2_kbmatrix;
    localparam int unsigned FILT_LEN    = 8;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int unsigned HALF        = 30;
    localparam int unsigned SETTLE      = 20;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ps2_kbmatrix_if bus();

    ps2_kbmatrix #(
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_mat = '1;

    // Capture every strobe/error the DUT produces
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.scan_stb)  obs_q.push_back('{err: 1'b0, code: bus.scan_code});
            if (bus.frame_err) obs_q.push_back('{err: 1'b1, code: 8'h00});
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_dat = b[i];
            wait_cyc(HALF);
            bus.ps2_clk = 1'b0;
            wait_cyc(HALF);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_q.push_back('{err: 1'b0, code: d});
        send_bits(mk_frame(d, 1'b0, 1'b1), 11);
    endtask

    task automatic test_reset;
        wait_cyc(5);
        @(negedge clk);
        n_cmp++;
        if (bus.kbmatrix !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL reset_kbmatrix got %h want %h", bus.kbmatrix, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        n_cmp++;
        if (bus.scan_code !== 8'h00) begin
            n_bad++; $display("FAIL reset_scan_code got %h want 00", bus.scan_code);
        end
        n_cmp++;
        if ({bus.scan_stb, bus.frame_err} !== 2'b00) begin
            n_bad++; $display("FAIL reset_pulses got stb=%b err=%b want 0 0", bus.scan_stb, bus.frame_err);
        end
        reset = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_reset_midframe;
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        reset = 1'b0;
        bus.ps2_dat = 1'b1;
        wait_cyc(TIMEOUT_CYC + 100);
        @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL midframe_reset_events got %0d want 0", obs_q.size());
            obs_q.delete();
        end
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL midframe_reset_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
    endtask

    task automatic test_make_break;
        ev_t e, o;
        send_byte(8'h1C);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[49] = 1'b0;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL make_A_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        n_cmp++;
        if (bus.scan_code !== 8'h1C) begin
            n_bad++; $display("FAIL make_A_scan_code_held got %h want 1c", bus.scan_code);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[49] = 1'b1;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL break_A_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL make_break_event got none want err=%b code=%h", e.err, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++; $display("FAIL make_break_event got err=%b code=%h want err=%b code=%h", o.err, o.code, e.err, e.code);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL make_break_extra got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        ev_t e, o;
        send_byte(8'h12);
        send_byte(8'h5A);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[62] = 1'b0;
        exp_mat[6]  = 1'b0;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL two_held_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        send_byte(8'h5A);
        send_byte(8'hAA);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat = '1;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL bat_clear_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL back_to_back_event got none want err=%b code=%h", e.err, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++; $display("FAIL back_to_back_event got err=%b code=%h want err=%b code=%h", o.err, o.code, e.err, e.code);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL back_to_back_extra got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_frame_errors;
        ev_t e, o;
        exp_q.push_back('{err: 1'b1, code: 8'h00});
        send_bits(mk_frame(8'h29, 1'b1, 1'b1), 11);
        exp_q.push_back('{err: 1'b1, code: 8'h00});
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11);
        bus.ps2_dat = 1'b1;
        wait_cyc(SETTLE);
        @(negedge clk);
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL frame_err_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL frame_err_event got none want err=%b code=%h", e.err, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++; $display("FAIL frame_err_event got err=%b code=%h want err=%b code=%h", o.err, o.code, e.err, e.code);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL frame_err_extra got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_timeout;
        ev_t e, o;
        exp_q.push_back('{err: 1'b1, code: 8'h00});
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 4);
        bus.ps2_dat = 1'b1;
        wait_cyc(TIMEOUT_CYC + 100);
        send_byte(8'h29);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[46] = 1'b0;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL timeout_then_space_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        send_byte(8'hF0);
        send_byte(8'h29);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[46] = 1'b1;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL space_release_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL timeout_event got none want err=%b code=%h", e.err, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++; $display("FAIL timeout_event got err=%b code=%h want err=%b code=%h", o.err, o.code, e.err, e.code);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL timeout_extra got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_ext_and_glitch;
        ev_t e, o;
        send_byte(8'hE0);
        send_byte(8'h75);
        wait_cyc(SETTLE);
        @(negedge clk);
`ifdef PS2_EXT_EN
        exp_mat[3] = 1'b0;
`endif
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL ext_up_make_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[3] = 1'b1;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL ext_up_break_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        // A short low pulse with data low would look like a start bit if it got through
        bus.ps2_dat = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        bus.ps2_clk = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        bus.ps2_clk = 1'b1;
        wait_cyc(SETTLE);
        bus.ps2_dat = 1'b1;
        wait_cyc(SETTLE);
        send_byte(8'h1C);
        wait_cyc(SETTLE);
        @(negedge clk);
        exp_mat[49] = 1'b0;
        n_cmp++;
        if (bus.kbmatrix !== exp_mat) begin
            n_bad++; $display("FAIL glitch_then_A_kbmatrix got %h want %h", bus.kbmatrix, exp_mat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL ext_glitch_event got none want err=%b code=%h", e.err, e.code);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++; $display("FAIL ext_glitch_event got err=%b code=%h want err=%b code=%h", o.err, o.code, e.err, e.code);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL ext_glitch_extra got %0d extra events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        test_reset();
        test_reset_midframe();
        test_make_break();
        test_back_to_back();
        test_frame_errors();
        test_timeout();
        test_ext_and_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
